// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the heart-rate monitor register-file arbiter.
package regfile_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int NREG       = 2 ** ADDR_W_DEF;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // Client index: 0 = sample capture unit, 1 = rate-processing unit.
  typedef logic client_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin choice; the last-granted client is held by the parent.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic    i_req0,
  input  logic    i_req1,
  input  client_t i_last,
  output logic    o_valid,
  output client_t o_winner
);

  // On contention the client that did not win last time goes next.
  assign o_valid  = i_req0 | i_req1;
  assign o_winner = (i_req0 & i_req1) ? ~i_last : i_req1;

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the register file's write port and port-A read between two clients,
// clears the file on reset or command, and passes port B through as a monitor.
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_resetN,
  input  logic              i_clr,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  input  logic [ADDR_W-1:0] i_monSel,
  output logic [DATA_W-1:0] o_monData,
  output logic [ADDR_W-1:0] o_rfSa,
  output logic [ADDR_W-1:0] o_rfSb,
  output logic [ADDR_W-1:0] o_rfDr,
  output logic              o_rfLd,
  output logic [DATA_W-1:0] o_rfDin,
  input  logic [DATA_W-1:0] i_rfDataA,
  input  logic [DATA_W-1:0] i_rfDataB
);

  localparam logic [ADDR_W-1:0] CntLast = ADDR_W'((2 ** ADDR_W) - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  client_t             r_last;
  client_t             r_cmdId;
  logic                r_cmdWe;
  logic [ADDR_W-1:0]   r_cmdAddr;
  logic [DATA_W-1:0]   r_cmdWdata;
  logic                r_gnt0;
  logic                r_gnt1;
  logic                r_rvalid0;
  logic                r_rvalid1;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_arbValid;
  client_t             w_arbWinner;
  logic                w_clearing;
  logic                w_writing;

  rr_arb2 u_arb (
    .i_req0   (i_req0),
    .i_req1   (i_req1),
    .i_last   (r_last),
    .o_valid  (w_arbValid),
    .o_winner (w_arbWinner)
  );

  // Grants and read-valids are single-cycle pulses, so they default low each edge.
  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      r_state    <= ST_CLEAR;
      r_cnt      <= '0;
      r_last     <= 1'b1;
      r_cmdId    <= 1'b0;
      r_cmdWe    <= 1'b0;
      r_cmdAddr  <= '0;
      r_cmdWdata <= '0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      unique case (r_state)
        ST_CLEAR: begin
          if (r_cnt == CntLast) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          // A clear request outranks any pending client access.
          if (i_clr) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
          end else if (w_arbValid) begin
            r_state    <= ST_ACCESS;
            r_last     <= w_arbWinner;
            r_cmdId    <= w_arbWinner;
            r_cmdWe    <= w_arbWinner ? i_we1 : i_we0;
            r_cmdAddr  <= w_arbWinner ? i_addr1 : i_addr0;
            r_cmdWdata <= w_arbWinner ? i_wdata1 : i_wdata0;
            r_gnt0     <= ~w_arbWinner;
            r_gnt1     <= w_arbWinner;
          end
        end
        ST_ACCESS: begin
          r_state <= ST_IDLE;
          if (!r_cmdWe) begin
            r_rdata   <= i_rfDataA;
            r_rvalid0 <= ~r_cmdId;
            r_rvalid1 <= r_cmdId;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign w_clearing = (r_state == ST_CLEAR);
  assign w_writing  = (r_state == ST_ACCESS) && r_cmdWe;

  // Load is gated by reset so an interrupted access never commits on the reset edge.
  assign o_rfLd    = i_resetN & (w_clearing | w_writing);
  assign o_rfDr    = w_clearing ? r_cnt : r_cmdAddr;
  assign o_rfDin   = w_clearing ? '0 : r_cmdWdata;
  assign o_rfSa    = r_cmdAddr;
  assign o_rfSb    = i_monSel;
  assign o_monData = i_rfDataB;

  assign o_busy    = w_clearing;
  assign o_gnt0    = r_gnt0;
  assign o_gnt1    = r_gnt1;
  assign o_rvalid0 = r_rvalid0;
  assign o_rvalid1 = r_rvalid1;
  assign o_rdata   = r_rdata;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed-vector bench for regfile_arbiter with a behavioural 8x8 register file.
module tb_regfile_arbiter;

  localparam int D = -1;

  typedef struct {
    bit resetN, clr, req0, we0;
    int addr0, wdata0;
    bit req1, we1;
    int addr1, wdata1, monSel;
  } in_t;

  typedef struct {
    int gnt0, gnt1, rvalid0, rvalid1, rdata, busy, ld, dr, din, sa, mon;
  } ex_t;

  typedef struct {
    in_t inp;
    ex_t ex;
  } vec_t;

  logic       clk = 1'b1;
  logic       resetN, clr, req0, req1, we0, we1;
  logic [2:0] addr0, addr1, monSel;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy, rfLd;
  logic [7:0] rdata, monData, rfDin, rfDataA, rfDataB;
  logic [2:0] rfSa, rfSb, rfDr;
  logic [7:0] rf [8];

  int vecCount  = 0;
  int missCount = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  regfile_arbiter dut (
    .i_clk     (clk),
    .i_resetN  (resetN),
    .i_clr     (clr),
    .i_req0    (req0),
    .i_req1    (req1),
    .i_we0     (we0),
    .i_we1     (we1),
    .i_addr0   (addr0),
    .i_addr1   (addr1),
    .i_wdata0  (wdata0),
    .i_wdata1  (wdata1),
    .o_gnt0    (gnt0),
    .o_gnt1    (gnt1),
    .o_rvalid0 (rvalid0),
    .o_rvalid1 (rvalid1),
    .o_rdata   (rdata),
    .o_busy    (busy),
    .i_monSel  (monSel),
    .o_monData (monData),
    .o_rfSa    (rfSa),
    .o_rfSb    (rfSb),
    .o_rfDr    (rfDr),
    .o_rfLd    (rfLd),
    .o_rfDin   (rfDin),
    .i_rfDataA (rfDataA),
    .i_rfDataB (rfDataB)
  );

  // Register file environment: synchronous write, asynchronous reads.
  always @(posedge clk) begin
    if (rfLd) rf[rfDr] <= rfDin;
  end
  assign rfDataA = rf[rfSa];
  assign rfDataB = rf[rfSb];

  function automatic in_t mkIn(bit rn, bit c, bit r0, bit w0, int a0, int d0,
                               bit r1, bit w1, int a1, int d1, int ms);
    in_t v;
    v.resetN = rn; v.clr = c;
    v.req0 = r0; v.we0 = w0; v.addr0 = a0; v.wdata0 = d0;
    v.req1 = r1; v.we1 = w1; v.addr1 = a1; v.wdata1 = d1;
    v.monSel = ms;
    return v;
  endfunction

  function automatic ex_t mkEx(int g0, int g1, int v0, int v1, int rd, int bz,
                               int ld, int dr, int din, int sa, int mon);
    ex_t e;
    e.gnt0 = g0; e.gnt1 = g1; e.rvalid0 = v0; e.rvalid1 = v1; e.rdata = rd;
    e.busy = bz; e.ld = ld; e.dr = dr; e.din = din; e.sa = sa; e.mon = mon;
    return e;
  endfunction

  task automatic addVec(input in_t i, input ex_t e);
    vec_t v;
    v.inp = i;
    v.ex  = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input in_t v);
    resetN = v.resetN;
    clr    = v.clr;
    req0   = v.req0;
    we0    = v.we0;
    addr0  = 3'(v.addr0);
    wdata0 = 8'(v.wdata0);
    req1   = v.req1;
    we1    = v.we1;
    addr1  = 3'(v.addr1);
    wdata1 = 8'(v.wdata1);
    monSel = 3'(v.monSel);
  endtask

  task automatic cmp(input int idx, input string name, input int act, input int exp);
    if (exp != D && act != exp) begin
      missCount++;
      $display("[TB] FAIL vec %0d %s: got %0h, want %0h", idx, name, act, exp);
    end
  endtask

  task automatic checkOutput(input int idx, input ex_t e);
    cmp(idx, "gnt0", int'(gnt0), e.gnt0);
    cmp(idx, "gnt1", int'(gnt1), e.gnt1);
    cmp(idx, "rvalid0", int'(rvalid0), e.rvalid0);
    cmp(idx, "rvalid1", int'(rvalid1), e.rvalid1);
    cmp(idx, "rdata", int'(rdata), e.rdata);
    cmp(idx, "busy", int'(busy), e.busy);
    cmp(idx, "rf_ld", int'(rfLd), e.ld);
    cmp(idx, "rf_dr", int'(rfDr), e.dr);
    cmp(idx, "rf_din", int'(rfDin), e.din);
    cmp(idx, "rf_sa", int'(rfSa), e.sa);
    cmp(idx, "mon_data", int'(monData), e.mon);
    cmp(idx, "rf_sb", int'(rfSb), int'(monSel));
  endtask

  // Inputs go on just after a rising edge; outputs are checked on the falling edge.
  task automatic runVec(input in_t i, input ex_t e);
    applyStimulus(i);
    @(negedge clk);
    checkOutput(vecCount, e);
    vecCount++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, then the power-on clear of R0..R7.
    addVec(mkIn(0,0,0,0,0,0,0,0,0,0,0), mkEx(D,D,D,D,D,D,D,D,D,D,D));
    addVec(mkIn(0,0,0,0,0,0,0,0,0,0,0), mkEx(0,0,0,0,0,1,0,D,D,0,D));
    for (int k = 0; k < 8; k++)
      addVec(mkIn(1,0,0,0,0,0,0,0,0,0,3), mkEx(0,0,0,0,0,1,1,k,0,0,D));
    // Preload R3 = A5 via client 0, read it back via client 1.
    addVec(mkIn(1,0,1,1,3,'hA5,0,0,0,0,3), mkEx(0,0,0,0,0,0,0,D,D,0,0));
    addVec(mkIn(1,0,0,0,0,0,0,0,0,0,3), mkEx(1,0,0,0,0,0,1,3,'hA5,3,0));
    addVec(mkIn(1,0,0,0,0,0,1,0,3,0,3), mkEx(0,0,0,0,0,0,0,D,D,3,'hA5));
    addVec(mkIn(1,0,0,0,0,0,0,0,0,0,3), mkEx(0,1,0,0,0,0,0,D,D,3,'hA5));
    // One-cycle reset pulse; both clients hold read requests through the clear.
    addVec(mkIn(0,0,0,0,0,0,0,0,0,0,3), mkEx(0,0,0,1,'hA5,0,0,D,D,3,'hA5));
    for (int k = 0; k < 8; k++)
      addVec(mkIn(1,0,1,0,3,0,1,0,5,0,3),
             mkEx(0,0,0,0,0,1,1,k,0,0,(k <= 3) ? 'hA5 : 0));
    addVec(mkIn(1,0,1,0,3,0,1,0,5,0,3), mkEx(0,0,0,0,0,0,0,D,D,0,0));
    addVec(mkIn(1,0,1,0,3,0,1,0,5,0,3), mkEx(1,0,0,0,0,0,0,D,D,3,0));
    addVec(mkIn(1,0,1,0,3,0,1,0,5,0,3), mkEx(0,0,1,0,0,0,0,D,D,3,0));
    addVec(mkIn(1,0,1,0,3,0,1,0,5,0,3), mkEx(0,1,0,0,0,0,0,D,D,5,0));
    addVec(mkIn(1,0,1,0,3,0,1,0,5,0,3), mkEx(0,0,0,1,0,0,0,D,D,5,0));
    addVec(mkIn(1,0,1,0,3,0,1,0,5,0,3), mkEx(1,0,0,0,0,0,0,D,D,3,0));
    addVec(mkIn(1,0,1,0,3,0,1,0,5,0,3), mkEx(0,0,1,0,0,0,0,D,D,3,0));
    addVec(mkIn(1,0,1,0,3,0,1,0,5,0,3), mkEx(0,1,0,0,0,0,0,D,D,5,0));
    // Client 0 writes R5 = 3C, client 1 reads it back.
    addVec(mkIn(1,0,1,1,5,'h3C,0,0,0,0,5), mkEx(0,0,0,1,0,0,0,D,D,5,0));
    addVec(mkIn(1,0,0,0,0,0,1,0,5,0,5), mkEx(1,0,0,0,0,0,1,5,'h3C,5,0));
    addVec(mkIn(1,0,0,0,0,0,1,0,5,0,5), mkEx(0,0,0,0,0,0,0,D,D,5,'h3C));
    addVec(mkIn(1,0,0,0,0,0,0,0,0,0,5), mkEx(0,1,0,0,0,0,0,D,D,5,'h3C));
    // CLR and REQ0 together: clear wins, then the write to R2 goes through.
    addVec(mkIn(1,1,1,1,2,'h7E,0,0,0,0,2), mkEx(0,0,0,1,'h3C,0,0,D,D,5,0));
    for (int k = 0; k < 8; k++)
      addVec(mkIn(1,0,1,1,2,'h7E,0,0,0,0,2), mkEx(0,0,0,0,'h3C,1,1,k,0,5,0));
    addVec(mkIn(1,0,1,1,2,'h7E,0,0,0,0,2), mkEx(0,0,0,0,'h3C,0,0,D,D,5,0));
    addVec(mkIn(1,0,0,0,0,0,0,0,0,0,2), mkEx(1,0,0,0,'h3C,0,1,2,'h7E,2,0));
    // Monitor on R2 while a commanded clear sweeps past it.
    addVec(mkIn(1,1,0,0,0,0,0,0,0,0,2), mkEx(0,0,0,0,'h3C,0,0,D,D,2,'h7E));
    for (int k = 0; k < 8; k++)
      addVec(mkIn(1,0,0,0,0,0,0,0,0,0,2),
             mkEx(0,0,0,0,'h3C,1,1,k,0,2,(k <= 2) ? 'h7E : 0));
    addVec(mkIn(1,0,0,0,0,0,1,0,2,0,2), mkEx(0,0,0,0,'h3C,0,0,D,D,2,0));

    #1;
    foreach (vecs[i]) runVec(vecs[i].inp, vecs[i].ex);

    // Reset lands during client 1's read ACCESS: no RVALID, RDATA cleared.
    runVec(mkIn(0,0,0,0,0,0,0,0,0,0,2), mkEx(0,1,0,0,'h3C,0,0,D,D,2,0));
    runVec(mkIn(1,0,0,0,0,0,0,0,0,0,2), mkEx(0,0,0,0,0,1,1,0,0,0,0));
    runVec(mkIn(1,0,0,0,0,0,0,0,0,0,2), mkEx(0,0,0,0,0,1,1,1,0,0,0));
    // Reset lands mid-CLEAR: the counter restarts at 0.
    runVec(mkIn(0,0,0,0,0,0,0,0,0,0,2), mkEx(0,0,0,0,0,1,0,D,D,0,0));
    runVec(mkIn(1,0,0,0,0,0,0,0,0,0,2), mkEx(0,0,0,0,0,1,1,0,0,0,0));
    runVec(mkIn(1,0,0,0,0,0,0,0,0,0,2), mkEx(0,0,0,0,0,1,1,1,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
